uart_mmio_fifo: RTL and testbench

- Memory-mapped UART controller for the CPU data bus, replacing the single-byte echo buffer between the byte-level UART receiver/transmitter and the core.
- Provides parametrised RX and TX FIFOs, status and control registers, sticky overflow flags, and a level interrupt into the CPU interrupt vector.
- Sits beside the data RAM wrapper on the same ce/we/addr/sel/data bus; the top level steers it by address decode.

---
 rtl/uart_mmio_fifo_pkg.sv | 47 ++++
 rtl/uart_mmio_fifo_sync_fifo.sv | 59 +++++
 rtl/uart_mmio_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_fifo_pkg.sv
// Shared definitions for the memory-mapped UART controller: register
// offsets (addr[3:2]), STATUS/CTRL bit positions, TX FSM state encoding and
// the STATUS word packer.
package uart_mmio_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_AVAIL    = 0;
  localparam int ST_TX_NOT_FULL = 1;
  localparam int ST_RX_OVF      = 2;
  localparam int ST_TX_IDLE     = 3;
  localparam int ST_TX_OVF      = 4;

  localparam int CTRL_RX_INT_EN = 0;
  localparam int CTRL_TX_INT_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic       rx_avail,
    input logic       tx_not_full,
    input logic       rx_ovf,
    input logic       tx_idle,
    input logic       tx_ovf,
    input logic [7:0] rx_cnt,
    input logic [7:0] tx_cnt
  );
    logic [31:0] st;
    st                 = '0;
    st[ST_RX_AVAIL]    = rx_avail;
    st[ST_TX_NOT_FULL] = tx_not_full;
    st[ST_RX_OVF]      = rx_ovf;
    st[ST_TX_IDLE]     = tx_idle;
    st[ST_TX_OVF]      = tx_ovf;
    st[15:8]           = rx_cnt;
    st[23:16]          = tx_cnt;
    return st;
  endfunction

endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// Synchronous FIFO with a look-ahead head output.
//   push/wdata : write request; accepted when not full, or when full and a
//                pop happens in the same cycle.
//   pop        : remove head; ignored when empty.
//   full/empty/count : occupancy (count is DEPTH_LOG2+1 bits).
//   head       : current front entry, readable without popping.
// Pointers and count are reset; storage is not.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART controller: RX/TX byte FIFOs between the byte-level
// UART and the CPU bus, with STATUS/CTRL registers, sticky overflow flags
// and a registered level interrupt.
//   clk, rst            : clock, synchronous active-high reset
//   ce_i/we_i/addr_i/sel_i/data_i/data_o : CPU bus (addr[3:2] decoded,
//                         sel[0] honoured, data_o combinational)
//   rx_valid_i/rx_data_i : received byte strobe from the UART receiver
//   tx_start_o/tx_data_o/tx_busy_i : transmitter handshake
//   int_o               : level interrupt
module uart_mmio_fifo
  import uart_mmio_fifo_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int BUSY_TIMEOUT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  output logic        int_o
);

  localparam int TMO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  logic [1:0]             reg_sel;
  logic                   acc;
  logic                   data_rd, data_wr, status_wr, ctrl_wr;
  logic                   rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic [7:0]             rx_head, tx_head;
  logic                   rx_pop, tx_pop;
  logic                   rx_ovf, tx_ovf;
  logic                   rx_ovf_set, tx_ovf_set;
  logic [1:0]             ctrl;
  logic                   tx_idle;
  tx_state_e              tx_state;
  logic [TMO_W-1:0]       wait_cnt;
  logic                   unused_bits;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], sel_i[3:1], data_i[31:8]};

  assign reg_sel   = addr_i[3:2];
  assign acc       = ce_i & sel_i[0];
  assign data_rd   = acc & ~we_i & (reg_sel == REG_DATA);
  assign data_wr   = acc &  we_i & (reg_sel == REG_DATA);
  assign status_wr = acc &  we_i & (reg_sel == REG_STATUS);
  assign ctrl_wr   = acc &  we_i & (reg_sel == REG_CTRL);

  assign rx_pop  = data_rd & ~rx_empty;
  assign tx_pop  = (tx_state == TX_START);
  assign tx_idle = tx_empty & (tx_state == TX_IDLE) & ~tx_busy_i;

  // Drops: full and no same-cycle pop to make room.
  assign rx_ovf_set = rx_valid_i & rx_full & ~rx_pop;
  assign tx_ovf_set = data_wr & tx_full & ~tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid_i), .wdata(rx_data_i), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(data_wr), .wdata(data_i[7:0]), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
  );

  always_comb begin
    data_o = '0;
    if (ce_i) begin
      case (reg_sel)
        REG_DATA:   data_o = {24'h0, rx_empty ? 8'h00 : rx_head};
        REG_STATUS: data_o = pack_status(~rx_empty, ~tx_full, rx_ovf, tx_idle, tx_ovf,
                                         8'(rx_count), 8'(tx_count));
        REG_CTRL:   data_o = {30'h0, ctrl};
        default:    data_o = '0;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
      ctrl   <= '0;
      int_o  <= 1'b0;
    end else begin
      if (status_wr && data_i[ST_RX_OVF]) rx_ovf <= 1'b0;
      if (rx_ovf_set)                     rx_ovf <= 1'b1;
      if (status_wr && data_i[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (tx_ovf_set)                     tx_ovf <= 1'b1;
      if (ctrl_wr)                        ctrl   <= data_i[1:0];
      int_o <= (ctrl[CTRL_RX_INT_EN] & ~rx_empty) | (ctrl[CTRL_TX_INT_EN] & tx_idle);
    end
  end

  // Outputs are loaded on the IDLE->START transition so the pulse and the
  // byte are both valid during the START cycle; tx_data_o then holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
      wait_cnt   <= '0;
    end else begin
      tx_start_o <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && !tx_busy_i) begin
            tx_state   <= TX_START;
            tx_start_o <= 1'b1;
            tx_data_o  <= tx_head;
          end
        end
        TX_START: begin
          tx_state <= TX_WAIT_HI;
          wait_cnt <= '0;
        end
        TX_WAIT_HI: begin
          if (tx_busy_i)                tx_state <= TX_WAIT_LO;
          else if (wait_cnt == TMO_LAST) tx_state <= TX_IDLE;
          else                          wait_cnt <= wait_cnt + 1'b1;
        end
        TX_WAIT_LO: begin
          if (!tx_busy_i) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
module tb_uart_mmio_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [3:0]  sel_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i;
  logic        int_o;

  always #5 clk = ~clk;

  uart_mmio_fifo #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4), .BUSY_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i), .int_o(int_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txexp[$];
  bit         rx_ovf_m = 0;
  bit         tx_ovf_m = 0;

  // Transmitter model and start-pulse log
  logic [7:0] start_log[$];
  int         start_cyc[$];
  int         cyc = 0;
  int         busy_cnt = 0;
  bit         busy_mode = 0;
  bit         busy_hold = 0;

  assign tx_busy_i = busy_hold | (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start_o) begin
      start_log.push_back(tx_data_o);
      start_cyc.push_back(cyc);
    end
    if (tx_start_o && busy_mode) busy_cnt <= 10;
    else if (busy_cnt > 0)       busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_i = 0; we_i = 0; addr_i = '0; sel_i = '0; data_i = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    ce_i = 1; we_i = 0; addr_i = a; sel_i = 4'h1; data_i = '0;
    #1;
    v = data_o;
    tick();
    bus_idle();
  endtask

  task automatic wr_sel(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce_i = 1; we_i = 1; addr_i = a; sel_i = s; data_i = d;
    tick();
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_sel(a, d, 4'h1);
  endtask

  // One cycle of RX traffic: optional strobe plus optional DATA read, with
  // the model updated from the rules (pre-cycle head returned, push accepted
  // if room or a real pop happens, otherwise overflow).
  task automatic cyc_op(input bit push, input logic [7:0] b, input bit pop);
    logic [7:0] exp;
    bit         popped, accept;
    exp    = (rxq.size() > 0) ? rxq[0] : 8'h00;
    popped = pop && (rxq.size() > 0);
    accept = push && ((rxq.size() < 16) || popped);
    rx_valid_i = push; rx_data_i = b;
    if (pop) begin ce_i = 1; we_i = 0; addr_i = 32'h0; sel_i = 4'h1; end
    #1;
    if (pop) check("rx_pop_data", data_o, {24'h0, exp});
    tick();
    rx_valid_i = 0;
    bus_idle();
    if (popped) void'(rxq.pop_front());
    if (accept) rxq.push_back(b);
    else if (push) rx_ovf_m = 1;
  endtask

  function automatic logic [31:0] exp_status(input bit txidle, input int txcnt);
    logic [31:0] s;
    s        = '0;
    s[0]     = rxq.size() > 0;
    s[1]     = txcnt < 16;
    s[2]     = rx_ovf_m;
    s[3]     = txidle;
    s[4]     = tx_ovf_m;
    s[15:8]  = 8'(rxq.size());
    s[23:16] = 8'(txcnt);
    return s;
  endfunction

  task automatic wait_starts(input int n, input int limit);
    int i;
    i = 0;
    while (start_log.size() < n && i < limit) begin
      tick();
      i++;
    end
    check("tx_start_count", 32'(start_log.size()), 32'(n));
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    int          k;

    rst = 1; bus_idle(); rx_valid_i = 0; rx_data_i = '0;
    repeat (3) tick();
    rst = 0;

    // Reset state
    check("rst_int", 32'(int_o), 32'h0);
    check("rst_tx_start", 32'(tx_start_o), 32'h0);
    check("rst_tx_data", 32'(tx_data_o), 32'h0);
    check("rst_dout_no_ce", data_o, 32'h0);
    rd(32'h4, v);
    check("rst_status", v, 32'h0000_000A);

    // RX ordering
    cyc_op(1, 8'h41, 0);
    cyc_op(1, 8'h42, 0);
    cyc_op(1, 8'h43, 0);
    rd(32'h4, v);
    check("rx3_status", v, exp_status(1, 0));
    check("rx3_count", 32'(v[15:8]), 32'd3);
    repeat (4) cyc_op(0, 8'h00, 1);
    rd(32'h4, v);
    check("rx_empty_status", v, exp_status(1, 0));

    // Randomised RX traffic against the queue model
    for (int r = 0; r < 80; r++) begin
      b = 8'($urandom);
      cyc_op($urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 3);
    end
    rd(32'h4, v);
    check("rx_rand_status", v, exp_status(1, 0));
    wr(32'h4, 32'h4);
    rx_ovf_m = 0;
    while (rxq.size() > 0) cyc_op(0, 8'h00, 1);
    rd(32'h4, v);
    check("rx_drained_status", v, exp_status(1, 0));

    // RX overflow: 17 strobes into depth 16
    for (int i = 0; i < 17; i++) cyc_op(1, 8'($urandom), 0);
    rd(32'h4, v);
    check("rx_ovf_status", v, exp_status(1, 0));
    check("rx_ovf_bit", 32'(v[2]), 32'h1);
    // Set and clear in the same cycle: set wins
    rx_valid_i = 1; rx_data_i = 8'hEE;
    wr(32'h4, 32'h4);
    rx_valid_i = 0;
    rd(32'h4, v);
    check("rx_ovf_set_wins", 32'(v[2]), 32'h1);
    wr(32'h4, 32'h4);
    rx_ovf_m = 0;
    rd(32'h4, v);
    check("rx_ovf_cleared", v, exp_status(1, 0));
    // Push on full with a simultaneous pop
    cyc_op(1, 8'h5A, 1);
    rd(32'h4, v);
    check("rx_full_pushpop", v, exp_status(1, 0));
    check("rx_full_count16", 32'(v[15:8]), 32'd16);
    while (rxq.size() > 0) cyc_op(0, 8'h00, 1);

    // CTRL / reserved / byte-enable
    wr(32'h8, 32'h3);
    rd(32'h8, v);
    check("ctrl_rw", v, 32'h3);
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'hC, v);
    check("rsvd_read", v, 32'h0);
    rd(32'h8, v);
    check("ctrl_after_rsvd", v, 32'h3);
    wr_sel(32'h8, 32'h0, 4'hE);
    rd(32'h8, v);
    check("ctrl_sel0_ignored", v, 32'h3);
    wr(32'h8, 32'h0);

    // TX path with a busy transmitter
    busy_mode = 1;
    start_log.delete(); start_cyc.delete();
    wr(32'h0, 32'h55);
    wr(32'h0, 32'hAA);
    wait_starts(2, 200);
    repeat (20) tick();
    check("tx_byte0", 32'(start_log[0]), 32'h55);
    check("tx_byte1", 32'(start_log[1]), 32'hAA);
    check("tx_gap_after_busy", 32'((start_cyc[1] - start_cyc[0]) >= 11), 32'h1);
    check("tx_data_hold", 32'(tx_data_o), 32'hAA);
    rd(32'h4, v);
    check("tx_idle_status", v, exp_status(1, 0));

    // Busy never rises: timeout path
    busy_mode = 0;
    start_log.delete(); start_cyc.delete(); txexp.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      txexp.push_back(b);
      wr(32'h0, {24'h0, b});
    end
    wait_starts(3, 200);
    repeat (10) tick();
    for (int i = 0; i < 3; i++) check("tx_tmo_byte", 32'(start_log[i]), 32'(txexp[i]));
    check("tx_tmo_gap0", 32'(start_cyc[1] - start_cyc[0]), 32'd5);
    check("tx_tmo_gap1", 32'(start_cyc[2] - start_cyc[1]), 32'd5);

    // TX overflow while the transmitter is held busy
    busy_hold = 1;
    start_log.delete(); start_cyc.delete(); txexp.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      txexp.push_back(b);
      wr(32'h0, {24'h0, b});
    end
    wr(32'h0, 32'h77);
    tx_ovf_m = 1;
    rd(32'h4, v);
    check("tx_ovf_status", v, exp_status(0, 16));
    wr(32'h4, 32'h10);
    tx_ovf_m = 0;
    rd(32'h4, v);
    check("tx_ovf_cleared", v, exp_status(0, 16));
    busy_hold = 0;
    k = 0;
    while (!tx_start_o && k < 20) begin tick(); k++; end
    check("tx_start_seen", 32'(tx_start_o), 32'h1);
    // Write on full during the pop cycle is accepted
    b = 8'hC3;
    txexp.push_back(b);
    wr(32'h0, {24'h0, b});
    rd(32'h4, v);
    check("tx_full_pushpop", v, exp_status(0, 16));
    wait_starts(17, 400);
    repeat (10) tick();
    for (int i = 0; i < 17; i++) check("tx_fifo_order", 32'(start_log[i]), 32'(txexp[i]));
    rd(32'h4, v);
    check("tx_final_status", v, exp_status(1, 0));

    // Interrupts
    wr(32'h8, 32'h1);
    check("int_off", 32'(int_o), 32'h0);
    cyc_op(1, 8'h99, 0);
    check("int_rx_lag", 32'(int_o), 32'h0);
    tick();
    check("int_rx_on", 32'(int_o), 32'h1);
    cyc_op(0, 8'h00, 1);
    check("int_rx_hold", 32'(int_o), 32'h1);
    tick();
    check("int_rx_off", 32'(int_o), 32'h0);
    wr(32'h8, 32'h2);
    tick();
    check("int_tx_idle", 32'(int_o), 32'h1);
    wr(32'h8, 32'h0);
    tick();
    check("int_disabled", 32'(int_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
